// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch unit: addressing-mode codes
// presented on the mode input, and the FSM state encoding.
// Ports: none (package).
package operand_fetch_pkg;

  // Addressing-mode codes. Codes 11..15 are illegal and finish with error=1.
  localparam logic [3:0] MODE_NONE           = 4'd0;
  localparam logic [3:0] MODE_IMMEDIATE      = 4'd1;
  localparam logic [3:0] MODE_A              = 4'd2;
  localparam logic [3:0] MODE_ZP             = 4'd3;
  localparam logic [3:0] MODE_INDEXED_X      = 4'd4;
  localparam logic [3:0] MODE_ABSOLUTE       = 4'd5;
  localparam logic [3:0] MODE_ABSOLUTE_X     = 4'd6;
  localparam logic [3:0] MODE_ABSOLUTE_Y     = 4'd7;
  localparam logic [3:0] MODE_STACK_RELATIVE = 4'd8;
  localparam logic [3:0] MODE_INDIRECT_X     = 4'd9;
  localparam logic [3:0] MODE_INDIRECT_Y     = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PTR_LO,
    S_PTR_HI,
    S_CALC,
    S_DONE
  } state_e;

  function automatic logic is_indirect(input logic [3:0] mode);
    return (mode == MODE_INDIRECT_X) || (mode == MODE_INDIRECT_Y);
  endfunction

endpackage

// File: rtl/operand_fetch_ea_calc.sv
// Combinational effective-address adder/mux used by operand_fetch.
// All sums are formed at REG_WIDTH and then truncated to ADDR_WIDTH.
// Configuration: INDIRECT_MODES_EN adds the pointer inputs/outputs and the
// INDIRECT_X/Y cases; without it those codes report mode_err with ea=0.
// Ports:
//   ptr16     in   16-bit pointer read from memory (indirect build only)
//   ptr_addr  out  address of the pointer low byte (indirect build only)
//   mode      in   addressing-mode code
//   nbytes    in   operand byte count (3 selects a full 24-bit absolute)
//   pc        in   address of the first operand byte
//   reg_x/reg_y/reg_sp/reg_dp  in  latched register values
//   operand   in   assembled operand bytes, little-endian
//   dbr       in   data bank for 16-bit absolute/indirect addresses
//   ea        out  effective address
//   mode_err  out  mode code is not supported
module operand_fetch_ea_calc
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int REG_WIDTH  = 32
) (
`ifdef INDIRECT_MODES_EN
  input  logic [15:0]           ptr16,
  output logic [ADDR_WIDTH-1:0] ptr_addr,
`endif
  input  logic [3:0]            mode,
  input  logic [2:0]            nbytes,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [REG_WIDTH-1:0]  reg_x,
  input  logic [REG_WIDTH-1:0]  reg_y,
  input  logic [REG_WIDTH-1:0]  reg_sp,
  input  logic [REG_WIDTH-1:0]  reg_dp,
  input  logic [REG_WIDTH-1:0]  operand,
  input  logic [7:0]            dbr,
  output logic [ADDR_WIDTH-1:0] ea,
  output logic                  mode_err
);

  logic [REG_WIDTH-1:0] op8;
  logic [REG_WIDTH-1:0] abs_v;
  logic [REG_WIDTH-1:0] sum;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    op8      = REG_WIDTH'(operand[7:0]);
    abs_v    = (nbytes == 3'd3) ? REG_WIDTH'(24'(operand))
                                : REG_WIDTH'({dbr, operand[15:0]});
    sum      = '0;
    mode_err = 1'b0;
    case (mode)
      MODE_NONE, MODE_A:   sum = '0;
      MODE_IMMEDIATE:      sum = REG_WIDTH'(pc);
      MODE_ZP:             sum = reg_dp + op8;
      MODE_INDEXED_X:      sum = reg_dp + op8 + reg_x;
      MODE_ABSOLUTE:       sum = abs_v;
      MODE_ABSOLUTE_X:     sum = abs_v + reg_x;
      MODE_ABSOLUTE_Y:     sum = abs_v + reg_y;
      MODE_STACK_RELATIVE: sum = reg_sp + op8;
`ifdef INDIRECT_MODES_EN
      MODE_INDIRECT_X, MODE_INDIRECT_Y:
        sum = REG_WIDTH'({dbr, ptr16}) + ((mode == MODE_INDIRECT_Y) ? reg_y : '0);
`endif
      default:             mode_err = 1'b1;
    endcase
    ea = ADDR_WIDTH'(sum);
  end

`ifdef INDIRECT_MODES_EN
  // Pointer location: dp+op8, pre-indexed by x for INDIRECT_X.
  assign ptr_addr = ADDR_WIDTH'(reg_dp + op8 + ((mode == MODE_INDIRECT_X) ? reg_x : '0));
`endif

endmodule

// File: rtl/operand_fetch.sv
// Sequential operand-fetch and effective-address unit. Reads the operand
// bytes following the opcode over a byte-wide request/ready handshake,
// optionally follows a 16-bit pointer, then returns operand and EA with a
// one-cycle done pulse.
// Configuration: define INDIRECT_MODES_EN to enable pointer reads for
// INDIRECT_X/Y; otherwise those modes fetch their bytes and end with error=1.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   start             request, sampled only in IDLE
//   mode, extra_bytes addressing mode and operand byte count
//   pc                address of the first operand byte
//   reg_x, reg_y, reg_sp, reg_dp, dbr   register inputs
//   mem_addr, mem_rd  read request (held stable until mem_ready)
//   mem_rdata, mem_ready  read response
//   busy, done, error status; error qualifies done
//   operand, ea       results, held until the next start
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int REG_WIDTH  = 32,
  parameter int MAX_EXTRA  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            mode,
  input  logic [2:0]            extra_bytes,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [REG_WIDTH-1:0]  reg_x,
  input  logic [REG_WIDTH-1:0]  reg_y,
  input  logic [REG_WIDTH-1:0]  reg_sp,
  input  logic [REG_WIDTH-1:0]  reg_dp,
  input  logic [7:0]            dbr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [REG_WIDTH-1:0]  operand,
  output logic [ADDR_WIDTH-1:0] ea
);

  state_e                state;
  logic [3:0]            mode_q;
  logic [2:0]            nbytes_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [REG_WIDTH-1:0]  x_q, y_q, sp_q, dp_q;
  logic [7:0]            dbr_q;
  logic                  byte_err_q;
  logic [1:0]            idx;
  logic [REG_WIDTH-1:0]  op_view;
  logic [ADDR_WIDTH-1:0] calc_ea;
  logic                  calc_err;
`ifdef INDIRECT_MODES_EN
  logic [15:0]           ptr16;
  logic [ADDR_WIDTH-1:0] ptr_addr;
`endif

  // Operand including the byte arriving this cycle, so the pointer address
  // can be formed on the same edge that captures the last operand byte.
  always_comb begin
    op_view = operand;
    if (state == S_FETCH && mem_ready)
      op_view[{idx, 3'b000} +: 8] = mem_rdata;
  end

  operand_fetch_ea_calc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .REG_WIDTH (REG_WIDTH)
  ) u_ea_calc (
`ifdef INDIRECT_MODES_EN
    .ptr16   (ptr16),
    .ptr_addr(ptr_addr),
`endif
    .mode    (mode_q),
    .nbytes  (nbytes_q),
    .pc      (pc_q),
    .reg_x   (x_q),
    .reg_y   (y_q),
    .reg_sp  (sp_q),
    .reg_dp  (dp_q),
    .operand (op_view),
    .dbr     (dbr_q),
    .ea      (calc_ea),
    .mode_err(calc_err)
  );

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      operand    <= '0;
      ea         <= '0;
      mode_q     <= '0;
      nbytes_q   <= '0;
      pc_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sp_q       <= '0;
      dp_q       <= '0;
      dbr_q      <= '0;
      byte_err_q <= 1'b0;
      idx        <= '0;
`ifdef INDIRECT_MODES_EN
      ptr16      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          mode_q     <= mode;
          nbytes_q   <= extra_bytes;
          pc_q       <= pc;
          x_q        <= reg_x;
          y_q        <= reg_y;
          sp_q       <= reg_sp;
          dp_q       <= reg_dp;
          dbr_q      <= dbr;
          operand    <= '0;
          idx        <= '0;
          busy       <= 1'b1;
          byte_err_q <= (extra_bytes > 3'(MAX_EXTRA));
`ifdef INDIRECT_MODES_EN
          ptr16      <= '0;
`endif
          // Illegal byte counts skip the fetch like extra_bytes=0, so the
          // error is reported from CALC with the same 2-cycle latency.
          if (extra_bytes == 3'd0 || extra_bytes > 3'(MAX_EXTRA)) begin
            state <= S_CALC;
          end else begin
            state    <= S_FETCH;
            mem_rd   <= 1'b1;
            mem_addr <= pc;
          end
        end
        S_FETCH: if (mem_ready) begin
          operand <= op_view;
          if ({1'b0, idx} == nbytes_q - 3'd1) begin
`ifdef INDIRECT_MODES_EN
            if (is_indirect(mode_q)) begin
              state    <= S_PTR_LO;
              mem_addr <= ptr_addr;
            end else
`endif
            begin
              mem_rd <= 1'b0;
              state  <= S_CALC;
            end
          end else begin
            idx      <= idx + 2'd1;
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end
`ifdef INDIRECT_MODES_EN
        S_PTR_LO: if (mem_ready) begin
          ptr16[7:0] <= mem_rdata;
          mem_addr   <= mem_addr + ADDR_WIDTH'(1);
          state      <= S_PTR_HI;
        end
        S_PTR_HI: if (mem_ready) begin
          ptr16[15:8] <= mem_rdata;
          mem_rd      <= 1'b0;
          state       <= S_CALC;
        end
`endif
        S_CALC: begin
          ea    <= byte_err_q ? '0 : calc_ea;
          error <= byte_err_q | calc_err;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic        clk, reset, start;
  logic [3:0]  mode;
  logic [2:0]  extra_bytes;
  logic [23:0] pc;
  logic [31:0] reg_x, reg_y, reg_sp, reg_dp;
  logic [7:0]  dbr;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        busy, done, error;
  logic [31:0] operand;
  logic [23:0] ea;

  int n_checks = 0;
  int n_fail   = 0;
  int wait_cycles = 0;
  int waited = 0;
  logic [7:0]  mem_ovr [int];
  logic [23:0] got_reads [$];
  logic [23:0] exp_reads [$];
  logic [31:0] obs_op;
  logic [23:0] obs_ea;
  logic        obs_err;
  int          obs_lat;

  operand_fetch dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .extra_bytes(extra_bytes),
    .pc(pc), .reg_x(reg_x), .reg_y(reg_y), .reg_sp(reg_sp), .reg_dp(reg_dp), .dbr(dbr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .error(error), .operand(operand), .ea(ea)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return a[7:0] ^ a[15:8] ^ {a[20:16], a[23:21]} ^ 8'h5a;
  endfunction

  // Memory responder: mem_ready after wait_cycles idle cycles per request;
  // random ready/data noise while no request is outstanding.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_rd && reset) begin
        if (waited >= wait_cycles) begin
          mem_ready = 1'b1;
          mem_rdata = mem_byte(mem_addr);
          got_reads.push_back(mem_addr);
          waited = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 8'($urandom);
          waited++;
        end
      end else begin
        waited    = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Reference: operand/EA/error/read list/latency from the addressing rules.
  task automatic model(input logic [3:0] m, input logic [2:0] nb, input logic [23:0] p,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] sp,
                       input logic [31:0] dp, input logic [7:0] b, input int w,
                       output logic [31:0] e_op, output logic [23:0] e_ea,
                       output logic e_err, output bit e_chk, output int e_lat);
    logic [31:0] s, absv, op8;
    logic [23:0] a, ptr;
    logic [15:0] p16;
    exp_reads.delete();
    e_op = 0; e_ea = 0; e_err = 0; e_chk = 1;
    if (nb > 3) begin
      e_err = 1; e_chk = 0; e_lat = 2;
      return;
    end
    for (int k = 0; k < int'(nb); k++) begin
      a = p + 24'(k);
      exp_reads.push_back(a);
      e_op = e_op | (32'(mem_byte(a)) << (8 * k));
    end
    op8  = e_op & 32'hFF;
    absv = (nb == 3) ? (e_op & 32'hFFFFFF) : ((32'(b) << 16) | (e_op & 32'hFFFF));
    s = 0;
    case (m)
      MODE_NONE, MODE_A:   s = 0;
      MODE_IMMEDIATE:      s = 32'(p);
      MODE_ZP:             s = dp + op8;
      MODE_INDEXED_X:      s = dp + op8 + x;
      MODE_ABSOLUTE:       s = absv;
      MODE_ABSOLUTE_X:     s = absv + x;
      MODE_ABSOLUTE_Y:     s = absv + y;
      MODE_STACK_RELATIVE: s = sp + op8;
      MODE_INDIRECT_X, MODE_INDIRECT_Y: begin
`ifdef INDIRECT_MODES_EN
        s   = dp + op8 + ((m == MODE_INDIRECT_X) ? x : 32'd0);
        ptr = s[23:0];
        exp_reads.push_back(ptr);
        exp_reads.push_back(ptr + 24'd1);
        p16 = {mem_byte(ptr + 24'd1), mem_byte(ptr)};
        s   = ((32'(b) << 16) | 32'(p16)) + ((m == MODE_INDIRECT_Y) ? y : 32'd0);
`else
        s = 0; e_err = 1;
`endif
      end
      default: begin e_err = 1; e_chk = 0; end
    endcase
    e_ea  = s[23:0];
    e_lat = 2 + exp_reads.size() * (1 + w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_op(input logic [3:0] m, input logic [2:0] nb, input logic [23:0] p,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] sp,
                        input logic [31:0] dp, input logic [7:0] b, input int w,
                        input bit hold);
    logic [31:0] e_op;
    logic [23:0] e_ea;
    logic        e_err;
    bit          e_chk;
    int          e_lat;
    int          lat;
    bit          seen;
    model(m, nb, p, x, y, sp, dp, b, w, e_op, e_ea, e_err, e_chk, e_lat);
    @(negedge clk);
    wait_cycles = w;
    got_reads.delete();
    mode = m; extra_bytes = nb; pc = p; reg_x = x; reg_y = y; reg_sp = sp; reg_dp = dp;
    dbr = b; start = 1'b1;
    lat = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        check("busy_after_start", busy, 1);
        if (!hold) start = 1'b0;
        // Inputs change after the request: results must come from latched copies.
        mode = 4'($urandom); extra_bytes = 3'($urandom); pc = 24'($urandom);
        reg_x = $urandom; reg_y = $urandom; reg_sp = $urandom; reg_dp = $urandom;
        dbr = 8'($urandom);
      end
      seen = done;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    if (!seen) begin
      do_reset();
      return;
    end
    obs_op = operand; obs_ea = ea; obs_err = error; obs_lat = lat;
    check("latency", lat, e_lat);
    check("error", error, e_err);
    check("operand", operand, e_op);
    if (e_chk) check("ea", ea, e_ea);
    check("n_reads", got_reads.size(), exp_reads.size());
    for (int i = 0; i < exp_reads.size() && i < got_reads.size(); i++)
      check("read_addr", got_reads[i], exp_reads[i]);
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("mem_rd_idle", mem_rd, 0);
    check("operand_hold", operand, e_op);
    if (e_chk) check("ea_hold", ea, e_ea);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = '0; extra_bytes = '0; pc = '0;
    reg_x = '0; reg_y = '0; reg_sp = '0; reg_dp = '0; dbr = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_operand", operand, 0);
    check("rst_ea", ea, 0);
    reset = 1'b1;

    // ZP: dp=0x100, byte 0x34 at 0x2001.
    mem_ovr.delete();
    mem_ovr[32'h2001] = 8'h34;
    run_op(MODE_ZP, 3'd1, 24'h002001, 0, 0, 0, 32'h100, 8'h00, 0, 0);
    check("zp_ea", obs_ea, 24'h000134);
    check("zp_operand", obs_op, 32'h34);
    check("zp_latency", obs_lat, 3);

    // ABSOLUTE_X, 3 bytes 0x10,0x20,0xFF, x=0x20.
    mem_ovr[32'h300] = 8'h10; mem_ovr[32'h301] = 8'h20; mem_ovr[32'h302] = 8'hFF;
    run_op(MODE_ABSOLUTE_X, 3'd3, 24'h000300, 32'h20, 0, 0, 0, 8'h7E, 0, 0);
    check("absx_operand", obs_op, 32'hFF2010);
    check("absx_ea", obs_ea, 24'hFF2030);

    // Operand bytes wrapping past the top of the address space, full-width sum wrap.
    mem_ovr[32'hFFFFFF] = 8'hF0; mem_ovr[32'h0] = 8'hFF; mem_ovr[32'h1] = 8'hFF;
    run_op(MODE_ABSOLUTE_Y, 3'd3, 24'hFFFFFF, 0, 32'h20, 0, 0, 8'h00, 1, 0);
    check("wrap_ea", obs_ea, 24'h000010);

`ifdef INDIRECT_MODES_EN
    // INDIRECT_Y with 2 wait cycles per read.
    mem_ovr[32'h500] = 8'h40; mem_ovr[32'h40] = 8'h00; mem_ovr[32'h41] = 8'h30;
    run_op(MODE_INDIRECT_Y, 3'd1, 24'h000500, 0, 32'd5, 0, 0, 8'h01, 2, 0);
    check("indy_ea", obs_ea, 24'h013005);
    check("indy_latency", obs_lat, 11);
`else
    run_op(MODE_INDIRECT_X, 3'd1, 24'h000500, 32'h3, 0, 0, 0, 8'h01, 0, 0);
    check("indx_disabled_error", obs_err, 1);
    check("indx_disabled_ea", obs_ea, 0);
`endif

    // Illegal byte count: no reads, error with done at cycle 2.
    run_op(MODE_ZP, 3'd4, 24'h001000, 0, 0, 0, 0, 8'h00, 0, 0);
    check("illegal_nb_error", obs_err, 1);
    check("illegal_nb_latency", obs_lat, 2);

    // IMMEDIATE with no operand bytes.
    run_op(MODE_IMMEDIATE, 3'd0, 24'h123456, 0, 0, 0, 0, 8'h00, 0, 0);
    check("imm_ea", obs_ea, 24'h123456);
    check("imm_operand", obs_op, 0);
    check("imm_latency", obs_lat, 2);

    // start held high through the whole operation.
    run_op(MODE_STACK_RELATIVE, 3'd2, 24'h004000, 0, 0, 32'h1FF, 0, 8'h00, 1, 1);

    // Reset while a fetch waits on mem_ready.
    @(negedge clk);
    wait_cycles = 1000;
    mode = MODE_ZP; extra_bytes = 3'd1; pc = 24'h00ABCD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_rd", mem_rd, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_mem_rd", mem_rd, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ea", ea, 0);
    check("midrst_operand", operand, 0);
    check("midrst_mem_addr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_cycles = 0;

    // Randomized operations against the reference.
    mem_ovr.delete();
    for (int t = 0; t < 48; t++) begin
      logic [3:0]  m;
      logic [2:0]  nb;
      logic [23:0] p;
      logic [31:0] dpv;
      m  = 4'($urandom_range(0, 15));
      nb = 3'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) nb = 3'($urandom_range(4, 7));
      else if ((m == MODE_NONE || m == MODE_A || m == MODE_IMMEDIATE) &&
               $urandom_range(0, 1) == 1) nb = 3'd0;
      p = 24'($urandom);
      if ($urandom_range(0, 4) == 0) p = 24'hFFFFFF - 24'($urandom_range(0, 2));
      dpv = $urandom;
      if ($urandom_range(0, 3) == 0) dpv = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
      run_op(m, nb, p, $urandom, $urandom, $urandom, dpv, 8'($urandom),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
